// File: rtl/round_robin_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter_pkg
// Shared definitions for the round-robin arbiter:
//   - state_t         : arbiter FSM state (IDLE / GRANTED)
//   - MAX_WIDTH       : largest requester count the index encoder supports
//   - onehot_to_bin() : one-hot to binary encoder used for grant_index
// -----------------------------------------------------------------------------
package round_robin_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    localparam int MAX_WIDTH       = 32;
    localparam int MAX_INDEX_WIDTH = $clog2(MAX_WIDTH);

    // OR-combines the indices of all set bits; for a one-hot input this is
    // exactly the index of the single set bit, and zero input gives zero.
    function automatic logic [MAX_INDEX_WIDTH-1:0] onehot_to_bin(
        input logic [MAX_WIDTH-1:0] onehot
    );
        logic [MAX_INDEX_WIDTH-1:0] index;
        index = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (onehot[i]) begin
                index = index | MAX_INDEX_WIDTH'(i);
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/first_one.sv
// -----------------------------------------------------------------------------
// first_one
// Priority block: isolates the lowest-indexed set bit of in_vector.
// Ports:
//   in_vector  input  WIDTH  candidate bits
//   first      output WIDTH  one-hot lowest set bit of in_vector (0 if none)
// -----------------------------------------------------------------------------
module first_one #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_vector,
    output logic [WIDTH-1:0] first
);

    // x & -x keeps only the least significant set bit.
    assign first = in_vector & (~in_vector + WIDTH'(1));

endmodule

// File: rtl/round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
// Shares one downstream resource between WIDTH requesters. Grants rotate in
// round-robin order; a grant is held until a valid/ready transfer completes,
// after which the just-served requester drops to lowest priority.
//
// Optional feature macro: ROUND_ROBIN_ARBITER_PACKET_LOCK_EN
//   When defined, the request_last port exists and the grant only moves on a
//   transfer that carries request_last for the granted requester, so
//   multi-beat packets are never interleaved.
//
// Ports:
//   clock         input  1            rising-edge clock
//   reset         input  1            asynchronous reset, active high
//   requests      input  WIDTH        per-requester request lines
//   request_last  input  WIDTH        last beat per requester (packet lock only)
//   grant_ready   input  1            downstream accepts the current transfer
//   grants        output WIDTH        registered one-hot grant
//   grant_valid   output 1            registered, equals |grants
//   grant_index   output INDEX_WIDTH  registered binary index of the grant
//
// WIDTH must be in the range 2..MAX_WIDTH (32).
// -----------------------------------------------------------------------------
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int INDEX_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       requests,
`ifdef ROUND_ROBIN_ARBITER_PACKET_LOCK_EN
    input  logic [WIDTH-1:0]       request_last,
`endif
    input  logic                   grant_ready,
    output logic [WIDTH-1:0]       grants,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] last_winner;
    logic [WIDTH-1:0] last_winner_next;
    logic [WIDTH-1:0] grants_next;

    logic [WIDTH-1:0] arb_pointer;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] masked_first;
    logic [WIDTH-1:0] all_first;
    logic [WIDTH-1:0] winner;
    logic             held;
    logic             transfer;
    logic             packet_end;
    logic             rearbitrate;

    // ------------------------------------------------------------------
    // Arbitration datapath
    // ------------------------------------------------------------------
    // While granted, a re-arbitration only happens on a transfer, and then
    // the current grant is the requester that must drop to lowest priority.
    assign arb_pointer = (state == GRANTED) ? grants : last_winner;

    // Keep only bits strictly above the pointer. With the pointer at the top
    // bit the shift yields zero, the mask becomes empty, and the unmasked
    // search wraps priority back to requester 0.
    assign masked = requests & ~((arb_pointer << 1) - WIDTH'(1));

    first_one #(.WIDTH(WIDTH)) u_first_masked (
        .in_vector (masked),
        .first     (masked_first)
    );

    first_one #(.WIDTH(WIDTH)) u_first_all (
        .in_vector (requests),
        .first     (all_first)
    );

    assign winner = (|masked) ? masked_first : all_first;

    // A granted requester that drops its request has broken the protocol;
    // that case is handled separately from a normal transfer.
    assign held     = |(requests & grants);
    assign transfer = grant_valid & grant_ready & held;

`ifdef ROUND_ROBIN_ARBITER_PACKET_LOCK_EN
    assign packet_end = |(request_last & grants);
`else
    assign packet_end = 1'b1;
`endif

    assign rearbitrate = transfer & packet_end;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|requests) state_next = GRANTED;
            GRANTED: if (!held)     state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        grants_next      = grants;
        last_winner_next = last_winner;
        case (state)
            IDLE: begin
                // winner is zero when nothing is requesting
                grants_next = winner;
            end
            GRANTED: begin
                if (!held) begin
                    grants_next = '0;
                end else if (rearbitrate) begin
                    // held implies requests is non-zero, so winner is too:
                    // the next grant follows with no idle cycle.
                    grants_next      = winner;
                    last_winner_next = grants;
                end
            end
            default: begin
                grants_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grants      <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
            last_winner <= {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            grants      <= grants_next;
            grant_valid <= |grants_next;
            grant_index <= INDEX_WIDTH'(onehot_to_bin(MAX_WIDTH'(grants_next)));
            last_winner <= last_winner_next;
        end
    end

endmodule
